// File: rtl/pipeline_controller.sv
// pipeline_controller: central sequencer for the five-stage core.
// Owns boot PC load, execute-stage jump redirect, the ebreak
// drain-and-halt sequence with resume, the per-stage flushes,
// the fetch stall and the cycle/instret counters.
module pipeline_controller #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decode_ready,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_jump_taken,
  input  logic [31:0] ex_jump_target,
  input  logic        ex_ebreak,
  input  logic        wb_retire,
  input  logic        resume,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic        stall_fetch,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} state_t;

  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  state_t      state;
  logic [3:0]  drain_cnt;
  logic [31:0] halt_pc;
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  // A taken jump outranks an ebreak resolved in the same instruction.
  logic jump_hit, ebreak_hit;
  assign jump_hit   = ex_valid && ex_jump_taken;
  assign ebreak_hit = ex_valid && ex_ebreak && !ex_jump_taken;

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

  // Sequencer state, halt capture, drain countdown and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      drain_cnt <= 4'd0;
      halt_pc   <= 32'd0;
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      if (state == RUN || state == DRAIN) cycle_q <= cycle_q + 32'd1;
      if (state != BOOT && wb_retire)     instret_q <= instret_q + 32'd1;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (ebreak_hit) begin
            halt_pc   <= ex_pc;
            drain_cnt <= DRAIN_LD;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt == 4'd1) state <= HALTED;
        end
        HALTED: if (resume) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  // Mealy outputs: redirect and resume act in the same cycle.
  always_comb begin
    pc_load      = 1'b0;
    pc_target    = ex_jump_target;
    flush_fetch  = 1'b0;
    flush_decode = 1'b0;
    stall_fetch  = 1'b0;
    halted       = 1'b0;
    case (state)
      BOOT: begin
        pc_load      = 1'b1;
        pc_target    = RESET_PC;
        flush_fetch  = 1'b1;
        flush_decode = 1'b1;
      end
      RUN: begin
        if (jump_hit) begin
          pc_load      = 1'b1;
          flush_fetch  = 1'b1;
          flush_decode = 1'b1;
        end else if (ebreak_hit) begin
          flush_fetch  = 1'b1;
          flush_decode = 1'b1;
          stall_fetch  = 1'b1;
        end else begin
          stall_fetch  = !decode_ready;
        end
      end
      DRAIN: begin
        flush_fetch  = 1'b1;
        flush_decode = 1'b1;
        stall_fetch  = 1'b1;
      end
      HALTED: begin
        halted       = 1'b1;
        flush_fetch  = 1'b1;
        flush_decode = 1'b1;
        stall_fetch  = !resume;
        pc_target    = halt_pc + 32'd4;
        pc_load      = resume;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a cycle-by-cycle vector table
// covering boot, hazard stall, jump, conflict/ignore rules, ebreak drain,
// halt and resume, plus hand sequences for reset-mid-drain and wrap.
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        decode_ready, ex_valid, ex_jump_taken, ex_ebreak, wb_retire, resume;
  logic [31:0] ex_pc, ex_jump_target;
  logic        pc_load, flush_fetch, flush_decode, stall_fetch, halted;
  logic [31:0] pc_target, cycle_count, instret_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipeline_controller #(.RESET_PC(32'h100), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .decode_ready(decode_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_jump_taken(ex_jump_taken), .ex_jump_target(ex_jump_target),
    .ex_ebreak(ex_ebreak), .wb_retire(wb_retire), .resume(resume),
    .pc_load(pc_load), .pc_target(pc_target), .flush_fetch(flush_fetch),
    .flush_decode(flush_decode), .stall_fetch(stall_fetch), .halted(halted),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  typedef struct {
    logic        dr, ev, jt, eb;
    logic [31:0] pc, tgt;
    logic        ret, res;
    logic        e_pl;
    logic [31:0] e_tgt;
    logic        e_ff, e_fd, e_st, e_h;
    logic [31:0] e_cy, e_ir;
  } vec_t;

  vec_t v[18];

  function automatic vec_t mk(logic dr, logic ev, logic jt, logic eb,
                              logic [31:0] pc, logic [31:0] tgt, logic ret, logic res,
                              logic pl, logic [31:0] etgt, logic ff, logic fd,
                              logic st, logic h, logic [31:0] cy, logic [31:0] ir);
    vec_t r;
    r.dr = dr; r.ev = ev; r.jt = jt; r.eb = eb; r.pc = pc; r.tgt = tgt;
    r.ret = ret; r.res = res; r.e_pl = pl; r.e_tgt = etgt; r.e_ff = ff;
    r.e_fd = fd; r.e_st = st; r.e_h = h; r.e_cy = cy; r.e_ir = ir;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    decode_ready = 1'b1; ex_valid = 1'b0; ex_jump_taken = 1'b0; ex_ebreak = 1'b0;
    ex_pc = 32'h0; ex_jump_target = 32'h0; wb_retire = 1'b0; resume = 1'b0;
  endtask

  task automatic chk_boot_outputs(input string tag);
    chk({tag, " pc_load"},      32'(pc_load),      32'd1);
    chk({tag, " pc_target"},    pc_target,         32'h100);
    chk({tag, " flush_fetch"},  32'(flush_fetch),  32'd1);
    chk({tag, " flush_decode"}, 32'(flush_decode), 32'd1);
    chk({tag, " stall_fetch"},  32'(stall_fetch),  32'd0);
    chk({tag, " halted"},       32'(halted),       32'd0);
  endtask

  initial begin
    //          dr ev jt eb pc        tgt       ret res  pl tgt       ff fd st h  cy  ir
    v[0]  = mk(1, 0, 0, 0, 32'h0,   32'h0,    1, 0,   1, 32'h100,  1, 1, 0, 0, 0,  0); // BOOT, retire ignored
    v[1]  = mk(1, 0, 0, 0, 32'h0,   32'h0,    0, 0,   0, 32'h0,    0, 0, 0, 0, 0,  0); // first RUN
    v[2]  = mk(0, 0, 0, 0, 32'h0,   32'h0,    0, 0,   0, 32'h0,    0, 0, 1, 0, 1,  0); // hazard
    v[3]  = mk(0, 0, 0, 0, 32'h0,   32'h0,    0, 0,   0, 32'h0,    0, 0, 1, 0, 2,  0); // hazard
    v[4]  = mk(1, 0, 0, 0, 32'h0,   32'h0,    1, 0,   0, 32'h0,    0, 0, 0, 0, 3,  0);
    v[5]  = mk(0, 1, 1, 0, 32'h0,   32'h2000, 0, 0,   1, 32'h2000, 1, 1, 0, 0, 4,  1); // jump
    v[6]  = mk(1, 1, 1, 1, 32'h80,  32'h3000, 0, 0,   1, 32'h3000, 1, 1, 0, 0, 5,  1); // jump+ebreak
    v[7]  = mk(1, 0, 0, 0, 32'h0,   32'h0,    0, 0,   0, 32'h0,    0, 0, 0, 0, 6,  1); // still RUN
    v[8]  = mk(1, 0, 0, 0, 32'h0,   32'h0,    0, 1,   0, 32'h0,    0, 0, 0, 0, 7,  1); // resume in RUN
    v[9]  = mk(1, 0, 1, 0, 32'h0,   32'h5000, 0, 0,   0, 32'h0,    0, 0, 0, 0, 8,  1); // unqualified jump
    v[10] = mk(1, 1, 0, 1, 32'h40,  32'h0,    0, 0,   0, 32'h0,    1, 1, 1, 0, 9,  1); // ebreak at t
    v[11] = mk(1, 1, 1, 0, 32'h0,   32'h5000, 1, 0,   0, 32'h0,    1, 1, 1, 0, 10, 1); // t+1 DRAIN, jump ignored
    v[12] = mk(1, 0, 0, 0, 32'h0,   32'h0,    1, 0,   0, 32'h0,    1, 1, 1, 0, 11, 2); // t+2 DRAIN
    v[13] = mk(1, 0, 0, 0, 32'h0,   32'h0,    0, 0,   0, 32'h0,    1, 1, 1, 1, 12, 3); // t+3 HALTED
    v[14] = mk(1, 0, 0, 0, 32'h0,   32'h0,    1, 0,   0, 32'h0,    1, 1, 1, 1, 12, 3); // t+4 retire in HALTED
    v[15] = mk(1, 0, 0, 0, 32'h0,   32'h0,    0, 1,   1, 32'h44,   1, 1, 0, 1, 12, 4); // t+5 resume
    v[16] = mk(1, 0, 0, 0, 32'h0,   32'h0,    0, 0,   0, 32'h0,    0, 0, 0, 0, 12, 4); // t+6 RUN
    v[17] = mk(1, 0, 0, 0, 32'h0,   32'h0,    0, 0,   0, 32'h0,    0, 0, 0, 0, 13, 4);

    idle();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk_boot_outputs("reset");
      chk("reset cycle_count",   cycle_count,   32'd0);
      chk("reset instret_count", instret_count, 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      decode_ready = v[i].dr; ex_valid = v[i].ev; ex_jump_taken = v[i].jt;
      ex_ebreak = v[i].eb; ex_pc = v[i].pc; ex_jump_target = v[i].tgt;
      wb_retire = v[i].ret; resume = v[i].res;
      #1;
      chk($sformatf("row%0d pc_load", i),      32'(pc_load),      32'(v[i].e_pl));
      if (v[i].e_pl) chk($sformatf("row%0d pc_target", i), pc_target, v[i].e_tgt);
      chk($sformatf("row%0d flush_fetch", i),  32'(flush_fetch),  32'(v[i].e_ff));
      chk($sformatf("row%0d flush_decode", i), 32'(flush_decode), 32'(v[i].e_fd));
      chk($sformatf("row%0d stall_fetch", i),  32'(stall_fetch),  32'(v[i].e_st));
      chk($sformatf("row%0d halted", i),       32'(halted),       32'(v[i].e_h));
      chk($sformatf("row%0d cycle_count", i),  cycle_count,       v[i].e_cy);
      chk($sformatf("row%0d instret", i),      instret_count,     v[i].e_ir);
      @(negedge clk);
    end

    // Reset asserted in the middle of DRAIN.
    idle();
    ex_valid = 1'b1; ex_ebreak = 1'b1; ex_pc = 32'h60;
    @(negedge clk);
    idle();
    #1;
    chk("drain stall_fetch", 32'(stall_fetch), 32'd1);
    chk("drain halted",      32'(halted),      32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_boot_outputs("midreset");
    chk("midreset cycle_count",   cycle_count,   32'd0);
    chk("midreset instret_count", instret_count, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk_boot_outputs("reboot");
    @(negedge clk); #1;
    chk("reboot run pc_load",     32'(pc_load),     32'd0);
    chk("reboot run flush_fetch", 32'(flush_fetch), 32'd0);
    chk("reboot run halted",      32'(halted),      32'd0);
    chk("reboot cycle_count0",    cycle_count,      32'd0);
    @(negedge clk); #1;
    chk("reboot cycle_count1",    cycle_count,      32'd1);

    // instret wrap from all-ones to zero.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    wb_retire = 1'b1;
    @(negedge clk);
    wb_retire = 1'b0;
    #1;
    chk("instret wrap", instret_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central sequencer for the five-stage core: fetch, decode, execute, memory, writeback. It owns the fetch PC redirect, the per-stage flush lines and the fetch stall, and gives reset-time PC loading one place to live. It also handles redirects from taken jumps in execute and the ebreak drain-and-halt sequence with resume, and keeps the cycle/instret counters. It sits beside the stages and consumes the decode `ready` handshake, execute's resolved jump/ebreak and writeback's retire strobe.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded into fetch after reset.
- DRAIN_CYCLES, 2: cycles needed for instructions older than the ebreak, in memory and writeback, to retire; legal range 1..15.

Ports (one clock; reset is asynchronous and active-low, named `clk` and `rst_n`):
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- decode_ready  in  1  decode stage `ready`; 0 means decode is stalling on a hazard.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_pc  in  32  PC of the execute-stage instruction.
- ex_jump_taken  in  1  execute resolved a taken jump/branch; qualified by ex_valid.
- ex_jump_target  in  32  redirect address.
- ex_ebreak  in  1  execute instruction is ebreak; qualified by ex_valid.
- wb_retire  in  1  writeback retires a valid instruction this cycle.
- resume  in  1  single-cycle request to leave HALTED.
- pc_load  out  1  fetch loads pc_target this cycle.
- pc_target  out  32  fetch PC to load.
- flush_fetch  out  1  invalidate the fetch→decode register.
- flush_decode  out  1  drives decode `flush`; invalidates decode output.
- stall_fetch  out  1  fetch holds its PC and output.
- halted  out  1  core is halted.
- cycle_count  out  32  cycles spent in RUN or DRAIN.
- instret_count  out  32  retired instructions.

## Operation

States: BOOT, RUN, DRAIN, HALTED. Reset enters BOOT. The counter `drain_cnt` is 4 bits. The register `halt_pc` is 32 bits.

- BOOT: pc_load=1, pc_target=RESET_PC, flush_fetch=1, flush_decode=1, stall_fetch=0. Unconditionally go to RUN next cycle.
- RUN, default: pc_load=0, no flushes, stall_fetch = !decode_ready.
- RUN with ex_valid & ex_jump_taken: in the same cycle (Mealy) assert pc_load=1, pc_target=ex_jump_target, flush_fetch=1, flush_decode=1, stall_fetch=0. State stays RUN.
- RUN with ex_valid & ex_ebreak & !ex_jump_taken:
  - Same cycle: flush_fetch=1, flush_decode=1, stall_fetch=1, pc_load=0.
  - Capture halt_pc=ex_pc, load drain_cnt=DRAIN_CYCLES, go to DRAIN.
- Jump and ebreak asserted together: jump wins, ebreak is ignored.
- DRAIN: flush_fetch=1, flush_decode=1, stall_fetch=1, jump/ebreak inputs ignored. drain_cnt decrements each cycle. When drain_cnt==1, go to HALTED.
- HALTED: halted=1, stall_fetch=1, flush_fetch=1, flush_decode=1.
  - resume=1: same cycle pc_load=1, pc_target=halt_pc+4 (32-bit wrap), stall_fetch=0. Go to RUN.
- resume outside HALTED is ignored.
- cycle_count increments in RUN and DRAIN, not in BOOT or HALTED.
- instret_count increments when wb_retire=1, in any state other than BOOT.
- Both counters are 32-bit and wrap from FFFF_FFFF to 0 without flag.

## Timing

- Reset values, held while rst_n=0: state BOOT, so pc_load=1, pc_target=RESET_PC, flush_fetch=1, flush_decode=1, stall_fetch=0, halted=0. Also cycle_count=0, instret_count=0, halt_pc=0, drain_cnt=0.
- Reset asserted mid-DRAIN or mid-HALTED returns to BOOT immediately, asynchronously. Nothing is retained.
- Redirect latency is 0 cycles: pc_load is combinational from ex_jump_taken. Fetch presents ex_jump_target on the next edge.
- Ebreak seen at edge-cycle t:
  - DRAIN occupies cycles t+1 .. t+DRAIN_CYCLES.
  - halted=1 from cycle t+DRAIN_CYCLES+1.
- Retires during DRAIN are counted.
- HALTED→RUN takes one cycle after resume. halted=0 in the cycle after resume.
- Outputs are functions of state and current inputs only. There are no combinational paths from pc_target to pc_load.

## Test plan

- Reset release: rst_n low 3 cycles, then high, RESET_PC=32'h100. Required: pc_load=1 and pc_target=0x100 during reset and the first cycle after release; RUN thereafter; both counters 0, then cycle_count=1 after the first RUN edge.
- Decode hazard: in RUN, decode_ready=0 for 2 cycles. Required: stall_fetch=1 exactly those 2 cycles, no flush, no pc_load.
- Jump: ex_valid=1, ex_jump_taken=1, ex_jump_target=0x2000. Required: same cycle pc_load=1, pc_target=0x2000, both flushes=1, stall_fetch=0; state stays RUN.
- Ebreak, drain and resume:
  - Stimulus: ebreak at ex_pc=0x40, cycle t, DRAIN_CYCLES=2, wb_retire=1 in t+1 and t+2, resume at t+5.
  - Required: halted=1 at t+3; instret_count +2; cycle_count frozen t+3..t+5.
  - Required at t+5: pc_load=1, pc_target=0x44.
  - Required at t+6: RUN, halted=0.
- Conflict and ignore rules:
  - ex_jump_taken and ex_ebreak both 1: redirect only, no DRAIN.
  - resume in RUN: no effect.
  - ex_jump_taken in DRAIN: no pc_load.
- Wrap and reset-mid-drain:
  - Force instret_count to FFFF_FFFF, then retire once. Required: reads 0.
  - Assert rst_n=0 during DRAIN. Required: outputs at reset values in the same cycle; BOOT sequence repeats.
